// File: rtl/prog_loader.sv
// UART-fed program loader: receives 8N1 frames and writes their payload into program memory.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    typedef enum logic [2:0] {
        WAIT_SYNC, ADDR_HI, ADDR_LO, LEN, DATA
`ifdef LOADER_CHECKSUM_EN
        , CSUM
`endif
    } ld_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            byte_valid_q;
    logic            frame_err_q;

    // The edge test runs one cycle after rx_sync_q falls, so the start-bit
    // check uses HALF-2 to land exactly HALF cycles after the synchronized edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= R_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                R_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= R_START;
                        rx_cnt_q   <= '0;
                    end
                end
                R_START: begin
                    if (rx_cnt_q == CW'(HALF - 2)) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= R_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_q     <= '0;
                        rx_state_q   <= R_IDLE;
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    ld_state_t             ld_state_q;
    logic [7:0]            addr_hi_q;
    logic [8:0]            remain_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_data_q;
    logic                  mem_we_q, cpu_hold_q, done_q, error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_state_q <= WAIT_SYNC;
            addr_hi_q  <= '0;
            remain_q   <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            end
            if (frame_err_q) begin
                error_q    <= 1'b1;
                ld_state_q <= WAIT_SYNC;
            end else if (byte_valid_q) begin
`ifdef LOADER_CHECKSUM_EN
                if (ld_state_q != WAIT_SYNC) begin
                    csum_q <= csum_q + rx_shift_q;
                end
`endif
                case (ld_state_q)
                    WAIT_SYNC: begin
                        if (rx_shift_q == 8'hA5) begin
                            ld_state_q <= ADDR_HI;
                            cpu_hold_q <= 1'b1;
                            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            csum_q     <= '0;
`endif
                        end
                    end
                    ADDR_HI: begin
                        addr_hi_q  <= rx_shift_q;
                        ld_state_q <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        mem_addr_q <= ADDR_WIDTH'({addr_hi_q, rx_shift_q});
                        ld_state_q <= LEN;
                    end
                    LEN: begin
                        remain_q   <= (rx_shift_q == 8'd0) ? 9'd256 : {1'b0, rx_shift_q};
                        ld_state_q <= DATA;
                    end
                    DATA: begin
                        mem_data_q <= rx_shift_q;
                        mem_we_q   <= 1'b1;
                        remain_q   <= remain_q - 9'd1;
                        if (remain_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            ld_state_q <= CSUM;
`else
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                            ld_state_q <= WAIT_SYNC;
`endif
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (csum_q + rx_shift_q == 8'd0) begin
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                        end
                        ld_state_q <= WAIT_SYNC;
                    end
`endif
                    default: ld_state_q <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;
endmodule
